// File: rtl/shift_register_ctrl_pkg.sv
// Shared types and widths for the shift_register controller:
// FSM state encoding, default geometry and a width helper.
package shreg_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int BUS_WIDTH_DEF = 32;
  localparam int NUM_REQ_DEF   = 4;

  // A 1-bit field is still needed to carry an index when only one value exists.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int IDW  = id_width(NUM_REQ_DEF);
  localparam int CNTW = $clog2(BUS_WIDTH_DEF) + 1;

endpackage

// File: rtl/shift_register_ctrl_if.sv
// Requester-side bus of shift_register_ctrl: levels, flattened words,
// directions, plus the grant and done strobes returned to the requesters.
interface shreg_ctrl_if #(
  parameter int BUS_WIDTH = 32,
  parameter int NUM_REQ   = 4
);

  logic [NUM_REQ-1:0]           i_req;
  logic [NUM_REQ*BUS_WIDTH-1:0] i_req_data;
  logic [NUM_REQ-1:0]           i_req_lr;
  logic [NUM_REQ-1:0]           o_gnt;
  logic [NUM_REQ-1:0]           o_done;

  modport master (
    output i_req, i_req_data, i_req_lr,
    input  o_gnt, o_done
  );

  modport slave (
    input  i_req, i_req_data, i_req_lr,
    output o_gnt, o_done
  );

endinterface

// File: rtl/shift_register_ctrl_rr_arbiter.sv
// Rotating-priority picker: first set request at or after ptr, wrapping.
// Purely combinational; the caller registers the result.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     idx,
  output logic               any
);

  // NOTE: every combinational output gets a default before the loop so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int pos;
      pos = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = IDW'(pos);
      end
    end
  end

endmodule

// File: rtl/shift_register_ctrl.sv
// Round-robin front end sharing one shift_register between NUM_REQ producers.
// Optional SHIFT watchdog is enabled by defining SHREG_CTRL_TIMEOUT_EN.
module shift_register_ctrl
  import shreg_ctrl_pkg::*;
#(
  parameter  int BUS_WIDTH      = BUS_WIDTH_DEF,
  parameter  int NUM_REQ        = NUM_REQ_DEF,
  parameter  int TIMEOUT_CYCLES = 80,
  localparam int ID_W           = id_width(NUM_REQ),
  localparam int CNT_W          = $clog2(BUS_WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shreg_ctrl_if.slave          req_if,
  output logic                 o_sr_ld,
  output logic                 o_sr_lr,
  output logic [BUS_WIDTH-1:0] o_sr_data,
  input  logic                 i_sr_busy,
  input  logic                 i_sr_valid,
  input  logic                 i_sr_shift,
  output logic                 o_ser_bit,
  output logic                 o_ser_valid,
  output logic [ID_W-1:0]      o_ser_id,
  output logic [CNT_W-1:0]     o_bit_cnt,
  output logic                 o_active,
  output logic                 o_timeout
);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                 sr_ld_q, sr_ld_d;
  logic                 sr_lr_q, sr_lr_d;
  logic [BUS_WIDTH-1:0] sr_data_q, sr_data_d;
  logic                 ser_bit_q, ser_bit_d;
  logic                 ser_valid_q, ser_valid_d;
  logic [ID_W-1:0]      ser_id_q, ser_id_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 seen_busy_q, seen_busy_d;
  logic                 active_q, active_d;
  logic                 timeout_q, timeout_d;
  logic                 wd_expire;
  logic                 normal_exit;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [ID_W-1:0]      arb_idx;
  logic                 arb_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (ID_W)
  ) u_arb (
    .req (req_if.i_req),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

`ifdef SHREG_CTRL_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] tmr_q, tmr_d;

  always_comb begin
    tmr_d     = (state_q == SHIFT) ? tmr_q + 1'b1 : '0;
    wd_expire = (state_q == SHIFT) && (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmr_q <= '0;
    else        tmr_q <= tmr_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign wd_expire          = 1'b0;
`endif

  assign normal_exit = seen_busy_q && !i_sr_busy;

  // NOTE: next-state logic uses blocking assignments on *_d only; the flops
  // below are the sole place state changes, always with non-blocking <=.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    id_d        = id_q;
    rr_ptr_d    = rr_ptr_q;
    sr_ld_d     = sr_ld_q;
    sr_lr_d     = sr_lr_q;
    sr_data_d   = sr_data_q;
    ser_bit_d   = ser_bit_q;
    ser_valid_d = 1'b0;
    ser_id_d    = ser_id_q;
    bit_cnt_d   = bit_cnt_q;
    seen_busy_d = seen_busy_q;
    timeout_d   = 1'b0;

    case (state_q)
      IDLE: begin
        sr_ld_d   = 1'b1;
        sr_data_d = '0;
        if (arb_any) begin
          state_d   = LOAD;
          gnt_d     = arb_gnt;
          id_d      = arb_idx;
          sr_data_d = req_if.i_req_data[int'(arb_idx)*BUS_WIDTH +: BUS_WIDTH];
          sr_lr_d   = req_if.i_req_lr[arb_idx];
          bit_cnt_d = '0;
        end
      end
      LOAD: begin
        state_d     = SHIFT;
        sr_ld_d     = 1'b0;
        seen_busy_d = 1'b0;
      end
      SHIFT: begin
        if (i_sr_busy) seen_busy_d = 1'b1;
        if (i_sr_valid) begin
          ser_valid_d = 1'b1;
          ser_bit_d   = i_sr_shift;
          ser_id_d    = id_q;
          if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 1'b1;
        end
        if (normal_exit || wd_expire) begin
          state_d   = DONE;
          done_d    = gnt_q;
          sr_ld_d   = 1'b1;
          sr_data_d = '0;
          timeout_d = wd_expire && !normal_exit;
        end
      end
      DONE: begin
        state_d  = IDLE;
        gnt_d    = '0;
        rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    active_d = (state_d != IDLE);
  end

  // NOTE: every register, including the wide data word, takes the async
  // reset so a mid-transfer reset leaves no stale grant, data or done behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      done_q      <= '0;
      id_q        <= '0;
      rr_ptr_q    <= '0;
      sr_ld_q     <= 1'b1;
      sr_lr_q     <= 1'b0;
      sr_data_q   <= '0;
      ser_bit_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_id_q    <= '0;
      bit_cnt_q   <= '0;
      seen_busy_q <= 1'b0;
      active_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      id_q        <= id_d;
      rr_ptr_q    <= rr_ptr_d;
      sr_ld_q     <= sr_ld_d;
      sr_lr_q     <= sr_lr_d;
      sr_data_q   <= sr_data_d;
      ser_bit_q   <= ser_bit_d;
      ser_valid_q <= ser_valid_d;
      ser_id_q    <= ser_id_d;
      bit_cnt_q   <= bit_cnt_d;
      seen_busy_q <= seen_busy_d;
      active_q    <= active_d;
      timeout_q   <= timeout_d;
    end
  end

  assign req_if.o_gnt  = gnt_q;
  assign req_if.o_done = done_q;
  assign o_sr_ld       = sr_ld_q;
  assign o_sr_lr       = sr_lr_q;
  assign o_sr_data     = sr_data_q;
  assign o_ser_bit     = ser_bit_q;
  assign o_ser_valid   = ser_valid_q;
  assign o_ser_id      = ser_id_q;
  assign o_bit_cnt     = bit_cnt_q;
  assign o_active      = active_q;
  assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_shift_register_ctrl.sv
// Bench for shift_register_ctrl paired with a simple serialiser model;
// round-robin order and bit streams come from a behavioural reference.
module tb_shift_register_ctrl;
  import shreg_ctrl_pkg::*;

  localparam int BW = 32;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shreg_ctrl_if #(.BUS_WIDTH(BW), .NUM_REQ(NR)) bus ();

  logic            o_sr_ld, o_sr_lr, o_ser_bit, o_ser_valid, o_active, o_timeout;
  logic [BW-1:0]   o_sr_data;
  logic [IDW-1:0]  o_ser_id;
  logic [CNTW-1:0] o_bit_cnt;
  logic            sr_busy, sr_valid, sr_shift, kill_busy;

  shift_register_ctrl #(.BUS_WIDTH(BW), .NUM_REQ(NR), .TIMEOUT_CYCLES(80)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_if      (bus),
    .o_sr_ld     (o_sr_ld),
    .o_sr_lr     (o_sr_lr),
    .o_sr_data   (o_sr_data),
    .i_sr_busy   (sr_busy & ~kill_busy),
    .i_sr_valid  (sr_valid),
    .i_sr_shift  (sr_shift),
    .o_ser_bit   (o_ser_bit),
    .o_ser_valid (o_ser_valid),
    .o_ser_id    (o_ser_id),
    .o_bit_cnt   (o_bit_cnt),
    .o_active    (o_active),
    .o_timeout   (o_timeout)
  );

  // Serialiser stand-in: loads while ld=1, then emits BW-1 beats.
  logic [BW-1:0] sh_reg;
  logic          sh_lr, sh_loaded;
  int            sh_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_reg <= '0; sh_lr <= 1'b0; sh_loaded <= 1'b0; sh_cnt <= 0;
      sr_busy <= 1'b0; sr_valid <= 1'b0; sr_shift <= 1'b0;
    end else if (o_sr_ld) begin
      sh_reg <= o_sr_data; sh_lr <= o_sr_lr; sh_loaded <= 1'b1; sh_cnt <= 0;
      sr_busy <= 1'b0; sr_valid <= 1'b0;
    end else if (sh_loaded) begin
      if (sh_cnt < BW - 1) begin
        sr_busy  <= 1'b1;
        sr_valid <= 1'b1;
        sr_shift <= sh_lr ? sh_reg[0] : sh_reg[BW-1];
        sh_reg   <= sh_lr ? (sh_reg >> 1) : (sh_reg << 1);
        sh_cnt   <= sh_cnt + 1;
      end else begin
        sr_busy <= 1'b0; sr_valid <= 1'b0; sh_loaded <= 1'b0;
      end
    end
  end

  int total = 0;
  int bad   = 0;
  int rr_m  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [NR-1:0] mask, input int ptr);
    for (int k = 0; k < NR; k++)
      if (mask[(ptr + k) % NR]) return (ptr + k) % NR;
    return -1;
  endfunction

  // Collects serial beats until a done pulse, a beat limit or the cycle budget.
  task automatic wait_done(input int exp_id, input int max_beats, output bit got_done,
                           output int beats, output logic [63:0] bits,
                           output bit id_ok, output bit one_hot_ok);
    got_done = 0; beats = 0; bits = '0; id_ok = 1; one_hot_ok = 1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (o_ser_valid) begin
        if (beats < 64) bits[beats] = o_ser_bit;
        if (int'(o_ser_id) != exp_id) id_ok = 0;
        beats++;
      end
      if ($countones(bus.o_gnt) > 1) one_hot_ok = 0;
      if (bus.o_done != '0) begin got_done = 1; return; end
      if (beats == max_beats) return;
    end
  endtask

  task automatic start_req(input logic [NR-1:0] mask, input logic [BW-1:0] wd,
                           input logic wlr, output int win);
    win = model_pick(mask, rr_m);
    for (int k = 0; k < NR; k++) begin
      bus.i_req_data[k*BW +: BW] = $urandom;
      bus.i_req_lr[k]            = 1'($urandom_range(0, 1));
    end
    bus.i_req_data[win*BW +: BW] = wd;
    bus.i_req_lr[win]            = wlr;
    bus.i_req                    = mask;
    @(negedge clk);
    check("gnt_load", bus.o_gnt, 64'(1) << win);
    check("ld_load", o_sr_ld, 1'b1);
    check("data_load", o_sr_data, wd);
    check("lr_load", o_sr_lr, wlr);
    check("active_load", o_active, 1'b1);
    check("cnt_clear", o_bit_cnt, 0);
    // Requester may change its word once granted; the controller must not care.
    bus.i_req_data[win*BW +: BW] = ~wd;
    bus.i_req_lr[win]            = ~wlr;
  endtask

  task automatic run_one(input logic [NR-1:0] mask, input logic [BW-1:0] wd,
                         input logic wlr, input bit keep);
    int win, beats;
    bit got, id_ok, oh_ok;
    logic [63:0] bits, expb;
    start_req(mask, wd, wlr, win);
    if (!keep) bus.i_req[win] = 1'b0;
    wait_done(win, 999, got, beats, bits, id_ok, oh_ok);
    check("done_seen", got, 1'b1);
    check("done_vec", bus.o_done, 64'(1) << win);
    check("gnt_in_done", bus.o_gnt, 64'(1) << win);
    check("no_timeout", o_timeout, 1'b0);
    check("beats", beats, BW - 1);
    expb = '0;
    for (int i = 0; i < BW - 1; i++) expb[i] = wlr ? wd[i] : wd[BW-1-i];
    check("bits", bits, expb);
    check("bit_cnt", o_bit_cnt, BW - 1);
    check("ser_id", id_ok, 1'b1);
    check("gnt_onehot", oh_ok, 1'b1);
    @(negedge clk);
    check("gnt_clear", bus.o_gnt, 0);
    check("done_pulse", bus.o_done, 0);
    check("idle", o_active, 1'b0);
    check("cnt_held", o_bit_cnt, BW - 1);
    rr_m = (win + 1) % NR;
  endtask

  initial begin
    int win, beats, k;
    bit got, id_ok, oh_ok, done_any;
    logic [63:0] bits;

    bus.i_req = '0; bus.i_req_data = '0; bus.i_req_lr = '0; kill_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ld", o_sr_ld, 1'b1);
    check("rst_data", o_sr_data, 0);
    check("rst_lr", o_sr_lr, 1'b0);
    check("rst_gnt", bus.o_gnt, 0);
    check("rst_done", bus.o_done, 0);
    check("rst_active", o_active, 1'b0);
    check("rst_valid", o_ser_valid, 1'b0);
    check("rst_timeout", o_timeout, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed: right shift emits LSB first, left shift MSB first.
    run_one(4'b0001, 32'h8000_0001, 1'b1, 1'b0);
    run_one(4'b0010, 32'h0000_0001, 1'b0, 1'b0);

    // All requesting continuously: strict rotation.
    for (int i = 0; i < 5; i++) run_one(4'b1111, $urandom, 1'($urandom_range(0, 1)), 1'b1);

    // Two contenders alternate, no starvation.
    for (int i = 0; i < 4; i++) run_one(4'b0101, $urandom, 1'($urandom_range(0, 1)), 1'b1);

    // Random masks and words.
    for (int i = 0; i < 8; i++)
      run_one(4'($urandom_range(1, 15)), $urandom, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    bus.i_req = '0;
    @(negedge clk);

    // Reset in the middle of SHIFT aborts the transfer.
    start_req(4'b1000, $urandom, 1'b1, win);
    bus.i_req = '0;
    wait_done(win, 10, got, beats, bits, id_ok, oh_ok);
    check("pre_abort_beats", beats, 10);
    rst_n = 1'b0;
    #1;
    check("abort_gnt", bus.o_gnt, 0);
    check("abort_ld", o_sr_ld, 1'b1);
    check("abort_data", o_sr_data, 0);
    check("abort_active", o_active, 1'b0);
    check("abort_cnt", o_bit_cnt, 0);
    done_any = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.o_done != '0) done_any = 1;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.o_done != '0) done_any = 1;
    end
    check("abort_no_done", done_any, 1'b0);
    rr_m = 0;
    run_one(4'b0100, $urandom, 1'($urandom_range(0, 1)), 1'b0);

    // Serialiser never reports busy: only the watchdog can end the transfer.
    kill_busy = 1'b1;
    start_req(4'b0010, $urandom, 1'b0, win);
    bus.i_req = '0;
`ifdef SHREG_CTRL_TIMEOUT_EN
    k = 0;
    got = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      k++;
      if (bus.o_done != '0) begin got = 1; break; end
    end
    check("wd_done_seen", got, 1'b1);
    check("wd_latency", k, 81);
    check("wd_timeout", o_timeout, 1'b1);
    check("wd_done_vec", bus.o_done, 64'(1) << win);
    @(negedge clk);
    check("wd_timeout_pulse", o_timeout, 1'b0);
    check("wd_idle", o_active, 1'b0);
    kill_busy = 1'b0;
    rr_m = (win + 1) % NR;
    run_one(4'b1111, $urandom, 1'($urandom_range(0, 1)), 1'b0);
`else
    done_any = 0;
    k = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.o_done != '0 || o_timeout) done_any = 1;
    end
    check("stuck_no_done", done_any, 1'b0);
    check("stuck_active", o_active, 1'b1);
    check("stuck_timeout", o_timeout, 1'b0);
    kill_busy = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rr_m = 0;
    run_one(4'b1111, $urandom, 1'($urandom_range(0, 1)), 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
